// File: rtl/invaders_pkg.sv
// Shared geometry, screen bounds and fleet state encoding for the invaders blocks.
// The draw block depends on the same constants, so any change here affects both.
package invaders_pkg;

    localparam int unsigned ALIEN_W       = 30;
    localparam int unsigned ALIEN_H       = 20;
    localparam int unsigned ALIEN_PITCH_X = 40;
    localparam int unsigned ALIEN_PITCH_Y = 30;
    localparam int unsigned NUM_COLS      = 10;
    localparam int unsigned NUM_ROWS      = 5;
    localparam int unsigned GRID_BITS     = NUM_COLS * NUM_ROWS;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EVAL,
        DONE
    } fleet_state_e;

    function automatic logic [2:0] highest_set_row(input logic [NUM_ROWS-1:0] rows);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (rows[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fleet_extent_scan.sv
// Walks a frozen alien grid one column per cycle and accumulates the live extents.
// done_o is high during the cycle that processes the last column.
module fleet_extent_scan
    import invaders_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [GRID_BITS-1:0] snap_i,
    output logic [3:0]           min_col_o,
    output logic [3:0]           max_col_o,
    output logic [2:0]           max_row_o,
    output logic                 any_live_o,
    output logic                 done_o
);

    localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

    logic                active_q, active_d;
    logic [3:0]          col_q, col_d;
    logic [3:0]          min_q, min_d;
    logic [3:0]          max_q, max_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                any_q, any_d;

    logic [NUM_COLS-1:0] row_bits [NUM_ROWS];
    logic [NUM_ROWS-1:0] col_bits;
    logic                col_live;

    always_comb begin
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            row_bits[r] = snap_i[r*NUM_COLS +: NUM_COLS];
            col_bits[r] = row_bits[r][col_q];
        end
        col_live = |col_bits;

        active_d = active_q;
        col_d    = col_q;
        min_d    = min_q;
        max_d    = max_q;
        rows_d   = rows_q;
        any_d    = any_q;

        if (abort_i) begin
            active_d = 1'b0;
            col_d    = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            col_d    = '0;
            min_d    = '0;
            max_d    = '0;
            rows_d   = '0;
            any_d    = 1'b0;
        end else if (active_q) begin
            if (col_live) begin
                if (!any_q) min_d = col_q;
                max_d = col_q;
                any_d = 1'b1;
            end
            rows_d = rows_q | col_bits;
            if (col_q == LAST_COL) begin
                active_d = 1'b0;
                col_d    = '0;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            col_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            rows_q   <= '0;
            any_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            col_q    <= col_d;
            min_q    <= min_d;
            max_q    <= max_d;
            rows_q   <= rows_d;
            any_q    <= any_d;
        end
    end

    assign done_o     = active_q && (col_q == LAST_COL);
    assign min_col_o  = min_q;
    assign max_col_o  = max_q;
    assign max_row_o  = highest_set_row(rows_q);
    assign any_live_o = any_q;

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Fleet origin sequencer: counts frames, scans a grid snapshot for live extents,
// then steps sideways or drops-and-reverses, flagging landing and annihilation.
module alien_fleet_ctrl
    import invaders_pkg::*;
#(
    parameter int unsigned STEP_FRAMES  = 8,
    parameter int unsigned DX           = 4,
    parameter int unsigned DY           = 10,
    parameter int unsigned START_COL    = 40,
    parameter int unsigned START_ROW    = 40,
    parameter int unsigned LEFT_LIMIT   = 0,
    parameter int unsigned RIGHT_LIMIT  = SCREEN_W,
    parameter int unsigned BOTTOM_LIMIT = SCREEN_H - 40
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 FrameTick,
    input  logic                 Enable,
    input  logic                 Restart,
    input  logic [GRID_BITS-1:0] Aliens_Grid,
    output logic [8:0]           AliensRow,
    output logic [9:0]           AliensCol,
    output logic                 Reached_Bottom,
    output logic                 FleetCleared,
    output logic                 StepPulse,
    output logic                 Busy
);

    fleet_state_e         state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [GRID_BITS-1:0] snap_q, snap_d;
    logic                 left_q, left_d;
    logic [9:0]           col_q, col_d;
    logic [8:0]           row_q, row_d;
    logic                 bottom_q, bottom_d;
    logic                 clear_q, clear_d;
    logic                 step_q, step_d;
    logic                 busy_q, busy_d;

    logic       scan_start, scan_done, any_live;
    logic [3:0] min_c, max_c;
    logic [2:0] max_r;

    logic        tick_ok, wrap;
    logic        hit_right, hit_left, at_edge, landed;
    logic [10:0] col_w, row_new;

    fleet_extent_scan u_scan (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .start_i    (scan_start),
        .abort_i    (Restart),
        .snap_i     (snap_q),
        .min_col_o  (min_c),
        .max_col_o  (max_c),
        .max_row_o  (max_r),
        .any_live_o (any_live),
        .done_o     (scan_done)
    );

    always_comb begin
        tick_ok = FrameTick && Enable && (state_q != DONE);
        wrap    = tick_ok && (cnt_q == 8'(STEP_FRAMES - 1));

        col_w     = {1'b0, col_q};
        hit_right = (col_w + 11'(max_c) * 11'(ALIEN_PITCH_X) + 11'(ALIEN_W) + 11'(DX))
                    > 11'(RIGHT_LIMIT);
        // The origin guard keeps the unsigned column from wrapping when the
        // leftmost columns are dead and the live edge never reaches the limit.
        hit_left  = ((col_w + 11'(min_c) * 11'(ALIEN_PITCH_X)) < (11'(LEFT_LIMIT) + 11'(DX)))
                    || (col_w < 11'(DX));
        at_edge   = left_q ? hit_left : hit_right;
        row_new   = {2'b00, row_q} + (at_edge ? 11'(DY) : 11'd0);
        landed    = (row_new + 11'(max_r) * 11'(ALIEN_PITCH_Y) + 11'(ALIEN_H))
                    > 11'(BOTTOM_LIMIT);

        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        snap_d     = snap_q;
        left_d     = left_q;
        col_d      = col_q;
        row_d      = row_q;
        bottom_d   = bottom_q;
        clear_d    = clear_q;
        step_d     = 1'b0;
        scan_start = 1'b0;

        if (tick_ok) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d     = 1'b0;
                    snap_d     = Aliens_Grid;
                    scan_start = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (scan_done) state_d = EVAL;
            end
            EVAL: begin
                if (!any_live) begin
                    clear_d = 1'b1;
                    state_d = DONE;
                end else begin
                    step_d = 1'b1;
                    if (at_edge) begin
                        row_d  = row_new[8:0];
                        left_d = ~left_q;
                    end else if (left_q) begin
                        col_d = col_q - 10'(DX);
                    end else begin
                        col_d = col_q + 10'(DX);
                    end
                    if (landed) begin
                        bottom_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // A wrap that coincides with IDLE taking the previous step must stay queued.
        if (wrap) pend_d = 1'b1;

        if (Restart) begin
            state_d    = IDLE;
            cnt_d      = '0;
            pend_d     = 1'b0;
            snap_d     = '0;
            left_d     = 1'b0;
            col_d      = 10'(START_COL);
            row_d      = 9'(START_ROW);
            bottom_d   = 1'b0;
            clear_d    = 1'b0;
            step_d     = 1'b0;
            scan_start = 1'b0;
        end

        busy_d = (state_d == SCAN) || (state_d == EVAL);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            snap_q   <= '0;
            left_q   <= 1'b0;
            col_q    <= 10'(START_COL);
            row_q    <= 9'(START_ROW);
            bottom_q <= 1'b0;
            clear_q  <= 1'b0;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            snap_q   <= snap_d;
            left_q   <= left_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bottom_q <= bottom_d;
            clear_q  <= clear_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
        end
    end

    assign AliensRow      = row_q;
    assign AliensCol      = col_q;
    assign Reached_Bottom = bottom_q;
    assign FleetCleared   = clear_q;
    assign StepPulse      = step_q;
    assign Busy           = busy_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Directed bench for alien_fleet_ctrl with STEP_FRAMES=8 and default geometry.
module tb_alien_fleet_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        FrameTick;
    logic        Enable;
    logic        Restart;
    logic [49:0] Aliens_Grid;
    logic [8:0]  AliensRow;
    logic [9:0]  AliensCol;
    logic        Reached_Bottom;
    logic        FleetCleared;
    logic        StepPulse;
    logic        Busy;

    int errors = 0;
    int checks = 0;

    logic [49:0] full_grid;
    logic [49:0] right_grid;

    always #5 Clk = ~Clk;

    alien_fleet_ctrl #(
        .STEP_FRAMES  (8),
        .DX           (4),
        .DY           (10),
        .START_COL    (40),
        .START_ROW    (40),
        .LEFT_LIMIT   (0),
        .RIGHT_LIMIT  (640),
        .BOTTOM_LIMIT (440)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .FrameTick      (FrameTick),
        .Enable         (Enable),
        .Restart        (Restart),
        .Aliens_Grid    (Aliens_Grid),
        .AliensRow      (AliensRow),
        .AliensCol      (AliensCol),
        .Reached_Bottom (Reached_Bottom),
        .FleetCleared   (FleetCleared),
        .StepPulse      (StepPulse),
        .Busy           (Busy)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_restart();
        Restart = 1'b1;
        cyc();
        Restart = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (lat < limit && !seen) begin
            cyc();
            lat++;
            if (StepPulse === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic quiet_cycles(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            cyc();
            if (StepPulse !== 1'b0) pulses++;
        end
    endtask

    task automatic step_n(input int n, output bit ok);
        int lat;
        bit seen;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            ticks(8);
            wait_pulse(30, lat, seen);
            if (!seen) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        FrameTick   = 1'b0;
        Enable      = 1'b1;
        Restart     = 1'b0;
        Aliens_Grid = full_grid;
        repeat (2) cyc();
        Reset_n = 1'b1;
        cyc();
        checks++; if (AliensCol !== 10'd40) begin errors++; $display("FAIL reset_col: got %0d expected 40", AliensCol); end
        checks++; if (AliensRow !== 9'd40) begin errors++; $display("FAIL reset_row: got %0d expected 40", AliensRow); end
        checks++; if ({Reached_Bottom, FleetCleared, StepPulse, Busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {Reached_Bottom, FleetCleared, StepPulse, Busy});
        end
    endtask

    task automatic test_reset_midscan();
        int  pulses;
        int  lat;
        bit  seen;
        ticks(8);
        repeat (3) cyc();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midscan_busy: got %b expected 1", Busy); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (AliensCol !== 10'd40 || AliensRow !== 9'd40) begin
            errors++; $display("FAIL async_reset_origin: got col %0d row %0d expected 40 40", AliensCol, AliensRow);
        end
        checks++; if ({Reached_Bottom, FleetCleared, StepPulse, Busy} !== 4'b0000) begin
            errors++; $display("FAIL async_reset_flags: got %b expected 0000", {Reached_Bottom, FleetCleared, StepPulse, Busy});
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        ticks(7);
        quiet_cycles(20, pulses);
        checks++; if (pulses != 0) begin errors++; $display("FAIL post_reset_7_ticks: got %0d pulses expected 0", pulses); end
        tick();
        wait_pulse(30, lat, seen);
        checks++; if (!seen || lat != 12) begin
            errors++; $display("FAIL post_reset_latency: got seen=%0d lat=%0d expected 12", seen, lat);
        end
        checks++; if (AliensCol !== 10'd44 || AliensRow !== 9'd40) begin
            errors++; $display("FAIL post_reset_step: got col %0d row %0d expected 44 40", AliensCol, AliensRow);
        end
    endtask

    task automatic test_step();
        int lat;
        bit seen;
        ticks(8);
        wait_pulse(30, lat, seen);
        checks++; if (!seen || lat != 12) begin
            errors++; $display("FAIL step_latency: got seen=%0d lat=%0d expected 12", seen, lat);
        end
        checks++; if (AliensCol !== 10'd48 || AliensRow !== 9'd40) begin
            errors++; $display("FAIL step_origin: got col %0d row %0d expected 48 40", AliensCol, AliensRow);
        end
        cyc();
        checks++; if (StepPulse !== 1'b0) begin errors++; $display("FAIL step_pulse_width: got %b expected 0", StepPulse); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL step_idle_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_enable_freeze();
        int pulses;
        int lat;
        bit seen;
        Enable = 1'b0;
        ticks(8);
        quiet_cycles(15, pulses);
        checks++; if (pulses != 0 || AliensCol !== 10'd48) begin
            errors++; $display("FAIL freeze: got %0d pulses col %0d expected 0 48", pulses, AliensCol);
        end
        Enable = 1'b1;
        ticks(8);
        wait_pulse(30, lat, seen);
        checks++; if (!seen || lat != 12 || AliensCol !== 10'd52) begin
            errors++; $display("FAIL unfreeze_step: got seen=%0d lat=%0d col %0d expected 1 12 52", seen, lat, AliensCol);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit seen;
        ticks(8);
        tick();
        Aliens_Grid = '0;
        ticks(7);
        wait_pulse(30, lat, seen);
        checks++; if (!seen || lat != 4 || AliensCol !== 10'd56) begin
            errors++; $display("FAIL b2b_first: got seen=%0d lat=%0d col %0d expected 1 4 56", seen, lat, AliensCol);
        end
        checks++; if (FleetCleared !== 1'b0) begin errors++; $display("FAIL b2b_snapshot: got cleared=%b expected 0", FleetCleared); end
        Aliens_Grid = full_grid;
        wait_pulse(30, lat, seen);
        checks++; if (!seen || lat != 12 || AliensCol !== 10'd60) begin
            errors++; $display("FAIL b2b_pending: got seen=%0d lat=%0d col %0d expected 1 12 60", seen, lat, AliensCol);
        end
    endtask

    task automatic test_right_edge();
        bit ok;
        pulse_restart();
        checks++; if (AliensCol !== 10'd40 || AliensRow !== 9'd40) begin
            errors++; $display("FAIL restart_origin: got col %0d row %0d expected 40 40", AliensCol, AliensRow);
        end
        step_n(52, ok);
        checks++; if (!ok || AliensCol !== 10'd248 || AliensRow !== 9'd40) begin
            errors++; $display("FAIL right_walk: got ok=%0d col %0d row %0d expected 1 248 40", ok, AliensCol, AliensRow);
        end
        step_n(1, ok);
        checks++; if (!ok || AliensCol !== 10'd248 || AliensRow !== 9'd50) begin
            errors++; $display("FAIL right_drop: got ok=%0d col %0d row %0d expected 1 248 50", ok, AliensCol, AliensRow);
        end
        step_n(1, ok);
        checks++; if (!ok || AliensCol !== 10'd244 || AliensRow !== 9'd50) begin
            errors++; $display("FAIL right_reverse: got ok=%0d col %0d row %0d expected 1 244 50", ok, AliensCol, AliensRow);
        end
    endtask

    task automatic test_left_edge();
        bit ok;
        pulse_restart();
        Aliens_Grid = right_grid;
        step_n(53, ok);
        checks++; if (!ok || AliensCol !== 10'd248 || AliensRow !== 9'd50) begin
            errors++; $display("FAIL left_setup: got ok=%0d col %0d row %0d expected 1 248 50", ok, AliensCol, AliensRow);
        end
        step_n(62, ok);
        checks++; if (!ok || AliensCol !== 10'd0 || AliensRow !== 9'd50) begin
            errors++; $display("FAIL left_walk: got ok=%0d col %0d row %0d expected 1 0 50", ok, AliensCol, AliensRow);
        end
        step_n(1, ok);
        checks++; if (!ok || AliensCol !== 10'd0 || AliensRow !== 9'd60) begin
            errors++; $display("FAIL left_drop: got ok=%0d col %0d row %0d expected 1 0 60", ok, AliensCol, AliensRow);
        end
        step_n(1, ok);
        checks++; if (!ok || AliensCol !== 10'd4 || AliensRow !== 9'd60) begin
            errors++; $display("FAIL left_reverse: got ok=%0d col %0d row %0d expected 1 4 60", ok, AliensCol, AliensRow);
        end
    endtask

    task automatic test_bottom();
        bit ok;
        int steps;
        int pulses;
        logic [9:0] frozen_col;
        Aliens_Grid = full_grid;
        ok    = 1'b1;
        steps = 0;
        while (ok && Reached_Bottom !== 1'b1 && steps < 2000) begin
            step_n(1, ok);
            steps++;
        end
        checks++; if (!ok || Reached_Bottom !== 1'b1) begin
            errors++; $display("FAIL bottom_reached: got ok=%0d flag=%b after %0d steps expected 1 1", ok, Reached_Bottom, steps);
        end
        checks++; if (AliensRow !== 9'd310) begin errors++; $display("FAIL bottom_row: got %0d expected 310", AliensRow); end
        frozen_col = AliensCol;
        ticks(8);
        quiet_cycles(20, pulses);
        checks++; if (pulses != 0 || AliensCol !== frozen_col || AliensRow !== 9'd310 || Busy !== 1'b0) begin
            errors++; $display("FAIL bottom_frozen: got pulses %0d col %0d row %0d busy %b expected 0 %0d 310 0",
                               pulses, AliensCol, AliensRow, Busy, frozen_col);
        end
        pulse_restart();
        checks++; if (AliensCol !== 10'd40 || AliensRow !== 9'd40 || Reached_Bottom !== 1'b0) begin
            errors++; $display("FAIL bottom_restart: got col %0d row %0d flag %b expected 40 40 0", AliensCol, AliensRow, Reached_Bottom);
        end
    endtask

    task automatic test_cleared();
        int pulses;
        Aliens_Grid = '0;
        ticks(8);
        quiet_cycles(20, pulses);
        checks++; if (FleetCleared !== 1'b1 || pulses != 0) begin
            errors++; $display("FAIL cleared: got flag %b pulses %0d expected 1 0", FleetCleared, pulses);
        end
        checks++; if (AliensCol !== 10'd40 || AliensRow !== 9'd40 || Reached_Bottom !== 1'b0) begin
            errors++; $display("FAIL cleared_origin: got col %0d row %0d bottom %b expected 40 40 0", AliensCol, AliensRow, Reached_Bottom);
        end
        Aliens_Grid = full_grid;
        ticks(8);
        quiet_cycles(20, pulses);
        checks++; if (pulses != 0 || FleetCleared !== 1'b1) begin
            errors++; $display("FAIL cleared_hold: got pulses %0d flag %b expected 0 1", pulses, FleetCleared);
        end
        pulse_restart();
        checks++; if (FleetCleared !== 1'b0) begin errors++; $display("FAIL cleared_restart: got %b expected 0", FleetCleared); end
    endtask

    initial begin
        full_grid  = '1;
        right_grid = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 3; c < 10; c++) right_grid[r*10 + c] = 1'b1;
        end

        test_reset();
        test_reset_midscan();
        test_step();
        test_enable_freeze();
        test_back_to_back();
        test_right_edge();
        test_left_edge();
        test_bottom();
        test_cleared();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
